fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter IMEM_DEPTH, default 256: instruction memory size in 32-bit words; power of two, 4..65536.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; word-aligned.
REQ-003 Parameter INIT_FILE, default "imem.hex": hex image for instruction memory; used only when FETCH_IMEM_INIT_EN is defined.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port pcSrc, input, 1: next-PC select; 1 selects pc_branched, 0 selects sequential PC.
REQ-007 Port pc_branched, input, 32: branch/jump target.
REQ-008 Port instruction, output, 32: instruction word at the current PC.
REQ-009 Port pc_out, output, 32: sequential PC, current PC + 4.

Function
REQ-010 The block SHALL hold one 32-bit PC register; it is the only sequential state besides memory contents.
REQ-011 The adder SHALL compute pc_out = PC + 32'd4, combinationally, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-012 The mux SHALL select next_pc = pcSrc ? pc_branched : pc_out, combinationally.
REQ-013 On each rising clk edge with rst_n high, PC SHALL load next_pc; one-cycle latency from pcSrc/pc_branched to PC.
REQ-014 pc_branched SHALL be loaded unmodified, including bits [1:0].
REQ-015 Instruction memory SHALL be word-organised, byte-addressed, read-only from the fetch side.
REQ-016 Memory read SHALL be combinational: instruction = mem[PC[log2(IMEM_DEPTH)+1:2]] within the same cycle PC changes.
REQ-017 PC[1:0] SHALL be ignored by the memory read.
REQ-018 If PC[31:log2(IMEM_DEPTH)+2] is nonzero (out of range), instruction SHALL be 32'h0000_0000.
REQ-019 An X or Z on pcSrc is not a supported input; no defined behaviour is required.

Reset
REQ-020 rst_n low SHALL force PC to RESET_PC immediately, independent of clk.
REQ-021 While rst_n is low: PC stays RESET_PC; pc_out = RESET_PC + 4; instruction = memory word at RESET_PC.
REQ-022 Reset asserted mid-operation SHALL discard any pending pcSrc/pc_branched selection.
REQ-023 Reset SHALL NOT alter memory contents.
REQ-024 On the first rising edge after rst_n deasserts, PC SHALL load next_pc normally.

Configuration
REQ-025 With FETCH_IMEM_INIT_EN defined, memory SHALL be loaded from INIT_FILE, hex words, at elaboration.
REQ-026 Without FETCH_IMEM_INIT_EN, every memory word SHALL initialise to 32'h0000_0000.
REQ-027 Without FETCH_IMEM_INIT_EN, instruction SHALL read 0 for all addresses.

Verification
REQ-028 Reset and sequential fetch. Setup: FETCH_IMEM_INIT_EN, image mem[k] = 32'h1000_0000 + k, rst_n low then high, pcSrc = 0. Required:
- while in reset: pc_out = 4, instruction = 32'h1000_0000;
- after 3 edges: pc_out = 16, instruction = 32'h1000_0003.
REQ-029 Branch. Setup: pcSrc = 1, pc_branched = 32'h0000_0040 for one edge, then pcSrc = 0. Required:
- after the branch edge: instruction = 32'h1000_0010, pc_out = 32'h44;
- after the next edge: pc_out = 32'h48.
REQ-030 Misaligned target. Stimulus: pc_branched = 32'h0000_0042 with pcSrc = 1. Required: instruction = 32'h1000_0010, pc_out = 32'h46.
REQ-031 Out of range and wrap. Stimulus: branch to 32'h0000_0400 (IMEM_DEPTH = 256), then branch to 32'hFFFF_FFFC. Required:
- at 32'h0000_0400: instruction = 0;
- at 32'hFFFF_FFFC: pc_out = 0;
- after one more edge with pcSrc = 0: instruction = 32'h1000_0000.
REQ-032 Asynchronous reset. Stimulus: pulse rst_n low between clock edges while PC = 32'h20. Required:
- pc_out = 4 before the next edge;
- memory contents unchanged.
REQ-033 Build without FETCH_IMEM_INIT_EN. Stimulus: run any fetch sequence. Required: instruction = 0 throughout.

Source files
------------

// File: rtl/fetch_imem_pkg.sv
package fetch_imem_pkg;

  function automatic logic [31:0] imem_word(input int unsigned k);
    return 32'h1000_0000 + k;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, +4 adder, next-PC mux and a combinational
// read-only instruction memory.
//
// Build option: FETCH_IMEM_INIT_EN
//   defined   - instruction memory is loaded with the image at elaboration.
//   undefined - every memory word is 32'h0000_0000, so instruction reads 0
//               for every address.
module fetch_stage #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter string       INIT_FILE  = "imem.hex"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcSrc,
    input  logic [31:0] pc_branched,
    output logic [31:0] instruction,
    output logic [31:0] pc_out
);

    localparam int AW = $clog2(IMEM_DEPTH);

    // Catch illegal configurations at elaboration rather than silently
    // producing a mis-sized memory.
    if ((IMEM_DEPTH < 4) || (IMEM_DEPTH > 65536) ||
        ((IMEM_DEPTH & (IMEM_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_stage: IMEM_DEPTH must be a power of two in 4..65536");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_stage: RESET_PC must be word-aligned");
    end

    logic [31:0]   pc;
    logic [31:0]   next_pc;
    logic [AW-1:0] word_idx;
    logic          out_of_range;
    logic [31:0]   mem [IMEM_DEPTH];

`ifdef FETCH_IMEM_INIT_EN
    // Preloaded ROM image; nothing on the fetch side ever writes it.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            mem[i] = fetch_imem_pkg::imem_word(i);
        end
    end
`else
    // No image: the memory is a constant all-zero ROM.
    for (genvar i = 0; i < IMEM_DEPTH; i++) begin : g_zero_mem
        assign mem[i] = 32'h0000_0000;
    end
`endif

    // Sequential PC wraps naturally modulo 2^32.
    assign pc_out  = pc + 32'd4;
    // Branch targets are taken verbatim, low bits included.
    assign next_pc = pcSrc ? pc_branched : pc_out;

    // Byte address -> word index; PC[1:0] never reaches the memory.
    assign word_idx     = pc[AW+1:2];
    // Any set bit above the memory window means the fetch is outside memory.
    assign out_of_range = (pc >> (AW + 2)) != 32'd0;

    // PC register: async reset to RESET_PC, otherwise load the selected next PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Combinational instruction read; out-of-window fetches return zero.
    always_comb begin
        instruction = 32'h0000_0000;
        if (!out_of_range) begin
            instruction = mem[word_idx];
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by randomized
// branch/sequential traffic with occasional asynchronous reset pulses,
// all checked against a behavioural PC/memory model.
module tb_fetch_stage;

    localparam int          DEPTH = 256;
    localparam int          AW    = 8;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcSrc;
    logic [31:0] pc_branched;
    logic [31:0] instruction;
    logic [31:0] pc_out;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mpc;

    fetch_stage #(
        .IMEM_DEPTH(DEPTH),
        .RESET_PC  (RPC),
        .INIT_FILE ("imem.hex")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pcSrc      (pcSrc),
        .pc_branched(pc_branched),
        .instruction(instruction),
        .pc_out     (pc_out)
    );

    always #5 clk = ~clk;

    // Expected memory word for a byte address: zero outside the window,
    // otherwise the image word (k-th word = 32'h1000_0000 + k) or zero.
    function automatic logic [31:0] ref_instr(input logic [31:0] addr);
        if ((addr / 32'd4) >= DEPTH) return 32'h0000_0000;
`ifdef FETCH_IMEM_INIT_EN
        return 32'h1000_0000 + (addr / 32'd4);
`else
        return 32'h0000_0000;
`endif
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".pc_out"}, pc_out, mpc + 32'd4);
        check_val({tag, ".instr"}, instruction, ref_instr(mpc));
    endtask

    // Drive selection, take one rising edge, update the model, settle.
    task automatic cycle(input logic src, input logic [31:0] tgt);
        pcSrc       = src;
        pc_branched = tgt;
        @(posedge clk);
        if (rst_n) mpc = src ? tgt : mpc + 32'd4;
        #1;
    endtask

    // Reset pulse wholly between two rising edges (called 1 unit after an edge).
    task automatic reset_pulse(input string tag);
        #3;
        rst_n = 1'b0;
        mpc   = RPC;
        #1;
        check_state(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic        src;
        logic [31:0] tgt;

        rst_n       = 1'b1;
        pcSrc       = 1'b0;
        pc_branched = 32'h0;
        mpc         = RPC;
        #2;
        rst_n = 1'b0;
        #1;
        check_state("reset");
        check_val("reset.pc_out_abs", pc_out, 32'd4);

        // Edge during reset with a branch request: must be ignored.
        cycle(1'b1, 32'h0000_0080);
        check_state("reset_hold");
        rst_n = 1'b1;

        // Sequential fetch: three edges -> PC = 12.
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        check_val("seq3.pc_out", pc_out, 32'd16);
        check_state("seq3");

        // Branch to 0x40, then sequential.
        cycle(1'b1, 32'h0000_0040);
        check_val("branch.pc_out", pc_out, 32'h44);
        check_state("branch");
        cycle(1'b0, 32'h0);
        check_val("branch_next.pc_out", pc_out, 32'h48);

        // Misaligned target is loaded unmodified.
        cycle(1'b1, 32'h0000_0042);
        check_val("misalign.pc_out", pc_out, 32'h46);
        check_state("misalign");

        // Out of range, wrap, and back into memory.
        cycle(1'b1, 32'h0000_0400);
        check_val("oor.instr", instruction, 32'h0);
        check_state("oor");
        cycle(1'b1, 32'hFFFF_FFFC);
        check_val("wrap.pc_out", pc_out, 32'h0);
        cycle(1'b0, 32'h0);
        check_state("wrap_next");
        check_val("wrap_next.pc_out", pc_out, 32'd4);

        // Async reset between edges while PC = 0x20, with a branch pending.
        cycle(1'b1, 32'h0000_0020);
        pcSrc       = 1'b1;
        pc_branched = 32'h0000_0080;
        reset_pulse("arst");
        check_val("arst.pc_out_abs", pc_out, 32'd4);
        cycle(1'b1, 32'h0000_0080);
        check_state("arst_after");
        cycle(1'b1, 32'h0000_0020);
        check_state("mem_kept");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            src = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom & 32'h0000_03FF;
                1:       tgt = $urandom;
                2:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: tgt = ($urandom & 32'h0000_00FF) << 2;
            endcase
            cycle(src, tgt);
            check_state("rand");
            if ($urandom_range(0, 24) == 0) reset_pulse("rand_arst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
